// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cacheline request into a 4-beat 64-bit memory burst.
// Read beats are assembled into line_o; write lines are sliced into beats.
module cacheline_adaptor #(
   parameter int LINE_WIDTH  = 256,
   parameter int BURST_WIDTH = 64,
   localparam int BEATS      = LINE_WIDTH / BURST_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [LINE_WIDTH-1:0]  line_i,
   output logic [LINE_WIDTH-1:0]  line_o,
   input  logic [31:0]            address_i,
   input  logic                   read_i,
   input  logic                   write_i,
   output logic                   resp_o,
   input  logic [BURST_WIDTH-1:0] burst_i,
   output logic [BURST_WIDTH-1:0] burst_o,
   output logic [31:0]            address_o,
   output logic                   read_o,
   output logic                   write_o,
   input  logic                   resp_i
);

   localparam int CW     = $clog2(BEATS);
   localparam int OFFSET = $clog2(LINE_WIDTH / 8);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                state;
   state_t                state_next;
   logic [CW-1:0]         count;
   logic [LINE_WIDTH-1:0] wline;
   logic                  last_beat;
   logic                  unused_offset;

   // Byte-offset bits are dropped by the line alignment.
   assign unused_offset = &{1'b0, address_i[OFFSET-1:0]};
   assign last_beat     = resp_i && (count == CW'(BEATS - 1));

   always_comb begin
      state_next = state;
      read_o     = 1'b0;
      write_o    = 1'b0;
      resp_o     = 1'b0;
      burst_o    = '0;
      case (state)
         IDLE: begin
            if (write_i) begin
               state_next = WRITE;
            end else if (read_i) begin
               state_next = READ;
            end
         end
         READ: begin
            read_o = 1'b1;
            if (last_beat) begin
               state_next = DONE;
            end
         end
         WRITE: begin
            write_o = 1'b1;
            burst_o = wline[int'(count)*BURST_WIDTH +: BURST_WIDTH];
            if (last_beat) begin
               state_next = DONE;
            end
         end
         DONE: begin
            resp_o     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The counter holds at the last beat; only DONE returns it to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         line_o    <= '0;
         address_o <= '0;
         wline     <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (write_i) begin
                  wline     <= line_i;
                  address_o <= {address_i[31:OFFSET], {OFFSET{1'b0}}};
               end else if (read_i) begin
                  address_o <= {address_i[31:OFFSET], {OFFSET{1'b0}}};
               end
            end
            READ: begin
               if (resp_i) begin
                  line_o[int'(count)*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                  count <= last_beat ? count : count + 1'b1;
               end
            end
            WRITE: begin
               if (resp_i) begin
                  count <= last_beat ? count : count + 1'b1;
               end
            end
            DONE: count <= '0;
            default: count <= '0;
         endcase
      end
   end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of the L1 arbiter: takes one full-line request (256-bit read or write) from the arbiter/L2 path and converts it into a 4-beat, 64-bit burst transaction on the physical memory port.
- Collects read beats into a line; slices write lines into beats.
- Returns a single-cycle line response upstream.

Parameters:
- LINE_WIDTH, 256, cacheline width in bits.
- BURST_WIDTH, 64, memory beat width in bits.
- BEATS, LINE_WIDTH/BURST_WIDTH (=4), beats per line. Derived; not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- line_i  in  256  write line from upstream; sampled at request acceptance.
- line_o  out  256  assembled read line; valid when resp_o=1 after a read.
- address_i  in  32  line address from upstream.
- read_i  in  1  upstream line read request; level, held until resp_o.
- write_i  in  1  upstream line write request; level, held until resp_o.
- resp_o  out  1  one-cycle completion pulse to upstream.
- burst_i  in  64  read beat from memory.
- burst_o  out  64  write beat to memory.
- address_o  out  32  burst address to memory, line-aligned.
- read_o  out  1  memory burst read request.
- write_o  out  1  memory burst write request.
- resp_i  in  1  memory beat strobe; one beat transferred per cycle it is high.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, beat counter=0, line_o=0, burst_o=0, address_o=0.
  - read_o, write_o and resp_o are all 0.
  - Reset overrides everything, including mid-burst. An aborted burst produces no resp_o.
- States:
  - IDLE: read_o/write_o/resp_o=0; resp_i ignored.
    - On write_i=1: latch line_i and address_i, go to WRITE.
    - Else on read_i=1: latch address_i, go to READ.
    - Write has priority if both are high.
  - READ:
    - read_o=1, address_o = {latched_addr[31:5], 5'b0}.
    - Each cycle resp_i=1: store burst_i into line_o[64k+63:64k] (k = beat counter), then k++.
    - When the beat with k=3 is stored: go to DONE.
    - resp_i=0 cycles stall without data loss; no timeout.
  - WRITE:
    - write_o=1, same aligned address_o.
    - burst_o = latched_line[64k+63:64k], driven combinationally from the counter.
    - Each cycle resp_i=1: k++. After the beat with k=3: go to DONE.
  - DONE:
    - resp_o=1 for exactly one cycle; read_o=write_o=0.
    - line_o holds the full read line. line_o keeps its value until the next read overwrites beats.
    - Unconditional transition to IDLE, with k cleared to 0.
- Latency:
  - Acceptance occurs on the edge after the request is seen in IDLE.
  - With resp_i high on 4 consecutive cycles, resp_o asserts in the cycle after the 4th beat.
  - Minimum request-to-resp_o is 6 cycles (1 IDLE + 4 beats + 1 DONE).
- Upstream rule: the requester drops read_i/write_i in the cycle after resp_o. A request still high in IDLE after DONE starts a new transaction.
- Latched values: address and write data are latched once. Changes to address_i/line_i mid-transaction are ignored.
- Counter: 2-bit counter; wraps 3→0 only via the DONE→IDLE clear, never mid-burst.
- read_o/write_o stay asserted continuously from the first beat through the last beat of a burst.

Test Plan:
- Read, no stalls: address_i=0x0000_1234, read_i=1; memory returns beats 0x1111..., 0x2222..., 0x3333..., 0x4444... on 4 consecutive resp_i cycles.
  - address_o=0x0000_1220.
  - resp_o pulses once, 6 cycles after the request.
  - line_o={0x4444..,0x3333..,0x2222..,0x1111..} (beat 0 in bits 63:0).
- Write: line_i = bytes 0x00..0x1F, address_i=0x8000_0040, write_i=1.
  - write_o held for 4 resp_i beats.
  - burst_o sequence: 0x0706050403020100, 0x0F0E0D0C0B0A0908, 0x1716151413121110, 0x1F1E1D1C1B1A1918.
  - Single resp_o.
- Stalled read: resp_i pattern 1,0,0,1,1,0,1.
  - Exactly 4 beats captured, in order.
  - resp_o one cycle after the final beat.
  - read_o stays high throughout.
- read_i=write_i=1 simultaneously: write burst executes, read_o never asserts, one resp_o.
- Reset mid-burst: assert rst after beat 2 of a read.
  - Next cycle read_o=0, resp_o=0, line_o=0.
  - A new read then completes normally with counter starting at beat 0.
- Back-to-back: drop the request after resp_o, then immediately issue a new read.
  - Second transaction is accepted from IDLE.
  - No spurious resp_o.
  - Stray resp_i in IDLE is ignored.
